// File: rtl/e1_rx_liu_ctrl.sv
// E1 RX LIU supervisor: qualifies the recovered LIU clock, forwards bits to
// the framer only while the clock is stable, flags loss of clock and loss
// of signal, and keeps a saturating clock-error counter.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ctrl_enable     0 holds the block in OFF
//   in_data/valid   recovered bit and its single-cycle strobe
//   out_data/valid  bit/strobe forwarded to the framer (RUN only, 1 cycle late)
//   status_clk_ok   1 while in RUN
//   status_los      loss-of-signal flag
//   err_cnt         saturating count of clock errors seen in RUN
//   err_clr         pulse, clears err_cnt
module e1_rx_liu_ctrl #(
    parameter int unsigned PER_MIN      = 12,
    parameter int unsigned PER_MAX      = 18,
    parameter int unsigned CLK_TIMEOUT  = 64,
    parameter int unsigned LOCK_BITS    = 256,
    parameter int unsigned LOS_ZEROS    = 255,
    parameter int unsigned LOS_CLR_ONES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_enable,
    input  logic        in_data,
    input  logic        in_valid,
    output logic        out_data,
    output logic        out_valid,
    output logic        status_clk_ok,
    output logic        status_los,
    output logic [15:0] err_cnt,
    input  logic        err_clr
);

    localparam int unsigned PER_W   = $clog2(CLK_TIMEOUT + 1);
    localparam int unsigned GOOD_W  = $clog2(LOCK_BITS + 1);
    localparam int unsigned ZERO_W  = $clog2(LOS_ZEROS + 1);
    localparam int unsigned WIN_LEN = 32;
    localparam int unsigned WIN_W   = $clog2(WIN_LEN);
    localparam int unsigned ONES_W  = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {S_OFF, S_WAIT, S_LOCK, S_RUN} state_t;

    state_t              r_state;
    logic [PER_W-1:0]    r_per_cnt;
    logic [GOOD_W-1:0]   r_good_cnt;
    logic [ZERO_W-1:0]   r_zero_cnt;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [ONES_W-1:0]   r_win_ones;
    logic                r_los;
    logic                r_clk_ok;
    logic                r_out_data;
    logic                r_out_valid;
    logic [15:0]         r_err_cnt;

    logic                w_in_range;
    logic                w_timeout;
    logic                w_err;
    logic [ONES_W-1:0]   w_ones_nxt;

    // Period classification; a strobe always wins over a timeout.
    always_comb begin
        w_in_range = (r_per_cnt >= PER_W'(PER_MIN)) && (r_per_cnt <= PER_W'(PER_MAX));
        w_timeout  = !in_valid && (r_per_cnt == PER_W'(CLK_TIMEOUT));
        w_err      = ctrl_enable && (r_state == S_RUN) &&
                     ((in_valid && !w_in_range) || w_timeout);
        w_ones_nxt = r_win_ones + ONES_W'(in_data);
    end

    // Link sequencing, forwarding, LOS tracking and error counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_OFF;
            r_per_cnt   <= '0;
            r_good_cnt  <= '0;
            r_zero_cnt  <= '0;
            r_win_cnt   <= '0;
            r_win_ones  <= '0;
            r_los       <= 1'b0;
            r_clk_ok    <= 1'b0;
            r_out_data  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (in_valid) begin
                r_per_cnt <= PER_W'(1);
            end else if (r_per_cnt != PER_W'(CLK_TIMEOUT)) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end

            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end

            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;

            if (!ctrl_enable) begin
                r_state    <= S_OFF;
                r_good_cnt <= '0;
                r_clk_ok   <= 1'b0;
                r_los      <= 1'b0;
                r_zero_cnt <= '0;
                r_win_cnt  <= '0;
                r_win_ones <= '0;
            end else begin
                case (r_state)
                    S_OFF: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (in_valid) begin
                            r_state    <= S_LOCK;
                            r_good_cnt <= '0;
                        end
                    end
                    S_LOCK: begin
                        if (in_valid) begin
                            if (w_in_range) begin
                                r_good_cnt <= r_good_cnt + GOOD_W'(1);
                                if (r_good_cnt == GOOD_W'(LOCK_BITS - 1)) begin
                                    r_state  <= S_RUN;
                                    r_clk_ok <= 1'b1;
                                end
                            end else begin
                                r_good_cnt <= '0;
                            end
                        end else if (w_timeout) begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_RUN: begin
                        if (in_valid) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_data;
                            // Recovery windows only run while LOS is already set.
                            if (r_los) begin
                                if (r_win_cnt == WIN_W'(WIN_LEN - 1)) begin
                                    if (w_ones_nxt >= ONES_W'(LOS_CLR_ONES)) begin
                                        r_los <= 1'b0;
                                    end
                                    r_win_cnt  <= '0;
                                    r_win_ones <= '0;
                                end else begin
                                    r_win_cnt  <= r_win_cnt + WIN_W'(1);
                                    r_win_ones <= w_ones_nxt;
                                end
                            end
                            if (in_data) begin
                                r_zero_cnt <= '0;
                            end else if (r_zero_cnt != ZERO_W'(LOS_ZEROS)) begin
                                r_zero_cnt <= r_zero_cnt + ZERO_W'(1);
                                if (r_zero_cnt == ZERO_W'(LOS_ZEROS - 1)) begin
                                    r_los <= 1'b1;
                                end
                            end
                        end else if (w_timeout) begin
                            r_state    <= S_WAIT;
                            r_clk_ok   <= 1'b0;
                            r_los      <= 1'b0;
                            r_zero_cnt <= '0;
                            r_win_cnt  <= '0;
                            r_win_ones <= '0;
                        end
                    end
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    assign out_data      = r_out_data;
    assign out_valid     = r_out_valid;
    assign status_clk_ok = r_clk_ok;
    assign status_los    = r_los;
    assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_e1_rx_liu_ctrl.sv
// Self-checking bench for e1_rx_liu_ctrl: randomized strobe spacing and data
// compared every cycle against a behavioural model, plus directed checks at
// the lock, timeout, LOS and saturation boundaries.
module tb_e1_rx_liu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_enable;
    logic        in_data;
    logic        in_valid;
    logic        err_clr;
    logic        out_data;
    logic        out_valid;
    logic        status_clk_ok;
    logic        status_los;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    e1_rx_liu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_enable  (ctrl_enable),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .status_clk_ok(status_clk_ok),
        .status_los   (status_los),
        .err_cnt      (err_cnt),
        .err_clr      (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: link mode, time of last strobe, good-period tally,
    // zero run length and a queue holding the current LOS recovery window.
    typedef enum int {M_OFF, M_WAIT, M_LOCK, M_RUN} mode_t;
    mode_t  m_mode;
    longint cyc = 0;
    longint last_strobe = 0;
    int     good;
    int     zrun;
    bit     los;
    bit     win[$];
    int     ecnt;
    bit     e_ov;
    bit     e_od;

    task automatic los_clear();
        los  = 1'b0;
        zrun = 0;
        win.delete();
    endtask

    task automatic los_bit(input bit d);
        int n;
        if (los) begin
            win.push_back(d);
            if (win.size() == 32) begin
                n = 0;
                foreach (win[k]) n += int'(win[k]);
                if (n >= 12) los = 1'b0;
                win.delete();
            end
        end
        if (d) zrun = 0;
        else begin
            zrun++;
            if (zrun == 255) los = 1'b1;
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit v, input bit d, input bit clr);
        longint age;
        bit     inr;
        bit     err;
        if (r) begin
            m_mode = M_OFF;
            good = 0;
            los_clear();
            ecnt = 0;
            e_ov = 1'b0;
            e_od = 1'b0;
            last_strobe = cyc + 1;
        end else begin
            age = cyc - last_strobe;
            if (age > 64) age = 64;
            inr  = (age >= 12) && (age <= 18);
            e_ov = 1'b0;
            e_od = 1'b0;
            err  = 1'b0;
            if (!en) begin
                m_mode = M_OFF;
                good = 0;
                los_clear();
            end else begin
                case (m_mode)
                    M_OFF: m_mode = M_WAIT;
                    M_WAIT: if (v) begin m_mode = M_LOCK; good = 0; end
                    M_LOCK: begin
                        if (v) begin
                            if (inr) begin
                                good++;
                                if (good == 256) m_mode = M_RUN;
                            end else good = 0;
                        end else if (age >= 64) m_mode = M_WAIT;
                    end
                    M_RUN: begin
                        if (v) begin
                            e_ov = 1'b1;
                            e_od = d;
                            if (!inr) err = 1'b1;
                            los_bit(d);
                        end else if (age >= 64) begin
                            err = 1'b1;
                            m_mode = M_WAIT;
                            los_clear();
                        end
                    end
                    default: m_mode = M_OFF;
                endcase
            end
            if (v) last_strobe = cyc;
            if (clr) ecnt = 0;
            else if (err && ecnt < 65535) ecnt++;
        end
        cyc++;
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic tick(input bit v, input bit d, input bit clr, input bit r);
        in_valid = v;
        in_data  = d;
        err_clr  = clr;
        rst      = r;
        @(posedge clk);
        model_step(r, ctrl_enable, v, d, clr);
        #1;
        check("out_valid", 32'(out_valid), 32'(e_ov));
        check("out_data", 32'(out_data), 32'(e_od));
        check("clk_ok", 32'(status_clk_ok), 32'(m_mode == M_RUN));
        check("los", 32'(status_los), 32'(los));
        check("err_cnt", 32'(err_cnt), 32'(ecnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
    endtask

    task automatic strobe(input bit d);
        tick(1'b1, d, 1'b0, 1'b0);
    endtask

    // n strobes, each preceded by a gap giving a random period in [lo,hi].
    task automatic periods(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            idle(int'($urandom_range(hi, lo)) - 1);
            strobe(1'($urandom));
        end
    endtask

    task automatic send_bits(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            idle(int'($urandom_range(18, 12)) - 1);
            strobe(pat[i]);
        end
    endtask

    function automatic logic [31:0] pat_k(input int k);
        logic [31:0] p = '0;
        while ($countones(p) < k) p[$urandom_range(31, 0)] = 1'b1;
        return p;
    endfunction

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_enable = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; err_clr = 1'b0;
        #1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_clk_ok", 32'(status_clk_ok), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);

        // Lock with periods spanning the whole accepted range.
        ctrl_enable = 1'b1;
        idle(3);
        strobe(1'b0);
        periods(254, 12, 18);
        idle(11); strobe(1'b1);
        check("lock_255", 32'(status_clk_ok), 32'd0);
        idle(17); strobe(1'b1);
        check("lock_256", 32'(status_clk_ok), 32'd1);
        check("lock_strobe_not_fwd", 32'(out_valid), 32'd0);
        idle(14); strobe(1'b1);
        check("fwd_latency", 32'(out_valid), 32'd1);
        check("fwd_data", 32'(out_data), 32'd1);
        idle(1);
        check("fwd_single", 32'(out_valid), 32'd0);
        periods(40, 12, 18);
        idle(18); strobe(1'b0);
        check("err_per19", 32'(err_cnt), 32'd1);
        idle(10); strobe(1'b0);
        check("err_per11", 32'(err_cnt), 32'd2);
        check("err_stay_run", 32'(status_clk_ok), 32'd1);
        idle(11); strobe(1'b1);
        check("per12_ok", 32'(err_cnt), 32'd2);
        idle(17); strobe(1'b1);
        check("per18_ok", 32'(err_cnt), 32'd2);

        // LOS: 255 zeros set it; an 11-ones window keeps it, 12 ones clear it.
        send_bits(32'd0, 32);
        send_bits(32'd0, 32);
        send_bits(32'd0, 32);
        send_bits(32'd0, 32);
        send_bits(32'd0, 32);
        send_bits(32'd0, 32);
        send_bits(32'd0, 32);
        send_bits(32'd0, 30);
        check("los_254", 32'(status_los), 32'd0);
        send_bits(32'd0, 1);
        check("los_255", 32'(status_los), 32'd1);
        send_bits(pat_k(11), 32);
        check("los_win11", 32'(status_los), 32'd1);
        begin
            logic [31:0] p = pat_k(12);
            send_bits(p, 31);
            check("los_win12_31", 32'(status_los), 32'd1);
            send_bits(p >> 31, 1);
            check("los_win12_clr", 32'(status_los), 32'd0);
        end

        // Back-to-back strobes: every period is 1, err_cnt saturates.
        for (int i = 0; i < 65540; i++) tick(1'b1, 1'($urandom), 1'b0, 1'b0);
        check("err_sat", 32'(err_cnt), 32'hFFFF);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("err_clr_wins", 32'(err_cnt), 32'd0);
        check("clr_no_state", 32'(status_clk_ok), 32'd1);

        // Loss of clock in RUN.
        idle(63);
        check("to_63", 32'(status_clk_ok), 32'd1);
        idle(1);
        check("to_64", 32'(status_clk_ok), 32'd0);
        check("to_err", 32'(err_cnt), 32'd1);
        idle(5);
        check("to_no_fwd", 32'(out_valid), 32'd0);

        // Bad period at good_cnt=200 restarts the lock count.
        strobe(1'b0);
        periods(200, 12, 13);
        idle(24); strobe(1'b1);
        periods(255, 12, 13);
        check("relock_255", 32'(status_clk_ok), 32'd0);
        periods(1, 12, 13);
        check("relock_256", 32'(status_clk_ok), 32'd1);

        // Enable drop mid-RUN, then a full relock.
        ctrl_enable = 1'b0;
        strobe(1'b1);
        check("off_clk_ok", 32'(status_clk_ok), 32'd0);
        check("off_no_fwd", 32'(out_valid), 32'd0);
        check("off_keeps_err", 32'(err_cnt), 32'd1);
        ctrl_enable = 1'b1;
        idle(3);
        strobe(1'b0);
        periods(255, 12, 13);
        check("reen_255", 32'(status_clk_ok), 32'd0);
        periods(1, 12, 13);
        check("reen_256", 32'(status_clk_ok), 32'd1);

        // Reset pulse mid-RUN clears everything including err_cnt.
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_run_clk_ok", 32'(status_clk_ok), 32'd0);
        check("rst_run_fwd", 32'(out_valid), 32'd0);
        check("rst_run_err", 32'(err_cnt), 32'd0);
        idle(4);
        periods(3, 12, 18);
        check("rst_no_run", 32'(status_clk_ok), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
